// File: rtl/ifft8_seq.sv
// 8-point radix-2 DIT inverse FFT: one shared real multiplier, frame-wide valid/ready handshakes.
// Optional build macro IFFT_ROUND_EN: round-half-up on the final 1/8 scaling instead of truncation.
module ifft8_seq #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int TW_C = 181
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_re,
  input  logic [8*DW-1:0] in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_re,
  output logic [8*DW-1:0] out_im
);

  localparam int GW = DW + 3;
  localparam int PW = GW + DW;
  localparam logic signed [DW-1:0] C = DW'(TW_C);

  typedef logic signed [GW-1:0] g_t;

  typedef enum logic [2:0] {
    IDLE, S12, M0, M1, M2, M3, S3, OUT
  } state_t;

  state_t r_state, w_next;

  logic signed [DW-1:0] r_xre [8];
  logic signed [DW-1:0] r_xim [8];
  g_t                   r_bre [8];
  g_t                   r_bim [8];
  g_t                   r_c   [4];
  logic [8*DW-1:0]      r_out_re, r_out_im;
  logic                 r_out_valid;

  logic                 w_accept;
  g_t                   w_are [8];
  g_t                   w_aim [8];
  g_t                   w_bre [8];
  g_t                   w_bim [8];
  g_t                   w_yre [8];
  g_t                   w_yim [8];
  g_t                   w_opd, w_m;
  logic signed [PW-1:0] w_prod;
  logic [8*DW-1:0]      w_out_re, w_out_im;

  function automatic g_t sx(input logic signed [DW-1:0] v);
    return g_t'(v);
  endfunction

  function automatic logic [DW-1:0] scale(input g_t v);
`ifdef IFFT_ROUND_EN
    logic signed [GW:0] t;
    t = (GW+1)'(v) + (GW+1)'(4);
    return DW'(t >>> 3);
`else
    return DW'(v >>> 3);
`endif
  endfunction

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = S12;
      S12:     w_next = M0;
      M0:      w_next = M1;
      M1:      w_next = M2;
      M2:      w_next = M3;
      M3:      w_next = S3;
      S3:      w_next = OUT;
      OUT:     if (r_out_valid && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stages 1+2 per half; half h consumes inputs h, h+4, h+2, h+6 (bit-reversed order).
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      w_are[k] = '0;
      w_aim[k] = '0;
      w_bre[k] = '0;
      w_bim[k] = '0;
    end
    for (int unsigned h = 0; h < 2; h++) begin
      w_are[4*h]   = sx(r_xre[h])   + sx(r_xre[h+4]);
      w_aim[4*h]   = sx(r_xim[h])   + sx(r_xim[h+4]);
      w_are[4*h+1] = sx(r_xre[h])   - sx(r_xre[h+4]);
      w_aim[4*h+1] = sx(r_xim[h])   - sx(r_xim[h+4]);
      w_are[4*h+2] = sx(r_xre[h+2]) + sx(r_xre[h+6]);
      w_aim[4*h+2] = sx(r_xim[h+2]) + sx(r_xim[h+6]);
      w_are[4*h+3] = sx(r_xre[h+2]) - sx(r_xre[h+6]);
      w_aim[4*h+3] = sx(r_xim[h+2]) - sx(r_xim[h+6]);

      w_bre[4*h]   = w_are[4*h] + w_are[4*h+2];
      w_bim[4*h]   = w_aim[4*h] + w_aim[4*h+2];
      w_bre[4*h+2] = w_are[4*h] - w_are[4*h+2];
      w_bim[4*h+2] = w_aim[4*h] - w_aim[4*h+2];
      w_bre[4*h+1] = w_are[4*h+1] - w_aim[4*h+3];
      w_bim[4*h+1] = w_aim[4*h+1] + w_are[4*h+3];
      w_bre[4*h+3] = w_are[4*h+1] + w_aim[4*h+3];
      w_bim[4*h+3] = w_aim[4*h+1] - w_are[4*h+3];
    end
  end

  always_comb begin
    w_opd = '0;
    case (r_state)
      M0:      w_opd = r_bre[5] - r_bim[5];
      M1:      w_opd = r_bre[5] + r_bim[5];
      M2:      w_opd = r_bre[7] + r_bim[7];
      M3:      w_opd = r_bre[7] - r_bim[7];
      default: w_opd = '0;
    endcase
  end

  assign w_prod = $signed(PW'(w_opd)) * $signed(PW'(C));
  assign w_m    = g_t'(w_prod >>> FRAC);

  // W1*b5 = (c0, c1), W3*b7 = (-c2, c3).
  always_comb begin
    w_yre[0] = r_bre[0] + r_bre[4];
    w_yim[0] = r_bim[0] + r_bim[4];
    w_yre[4] = r_bre[0] - r_bre[4];
    w_yim[4] = r_bim[0] - r_bim[4];
    w_yre[1] = r_bre[1] + r_c[0];
    w_yim[1] = r_bim[1] + r_c[1];
    w_yre[5] = r_bre[1] - r_c[0];
    w_yim[5] = r_bim[1] - r_c[1];
    w_yre[2] = r_bre[2] - r_bim[6];
    w_yim[2] = r_bim[2] + r_bre[6];
    w_yre[6] = r_bre[2] + r_bim[6];
    w_yim[6] = r_bim[2] - r_bre[6];
    w_yre[3] = r_bre[3] - r_c[2];
    w_yim[3] = r_bim[3] + r_c[3];
    w_yre[7] = r_bre[3] + r_c[2];
    w_yim[7] = r_bim[3] - r_c[3];
    w_out_re = '0;
    w_out_im = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_out_re[DW*k +: DW] = scale(w_yre[k]);
      w_out_im[DW*k +: DW] = scale(w_yim[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 8; k++) begin
        r_xre[k] <= '0;
        r_xim[k] <= '0;
        r_bre[k] <= '0;
        r_bim[k] <= '0;
      end
      for (int unsigned k = 0; k < 4; k++) r_c[k] <= '0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int unsigned k = 0; k < 8; k++) begin
              r_xre[k] <= in_re[DW*k +: DW];
              r_xim[k] <= in_im[DW*k +: DW];
            end
          end
        end
        S12: begin
          for (int unsigned k = 0; k < 8; k++) begin
            r_bre[k] <= w_bre[k];
            r_bim[k] <= w_bim[k];
          end
        end
        M0: r_c[0] <= w_m;
        M1: r_c[1] <= w_m;
        M2: r_c[2] <= w_m;
        M3: r_c[3] <= w_m;
        S3: begin
          r_out_re    <= w_out_re;
          r_out_im    <= w_out_im;
          r_out_valid <= 1'b1;
        end
        OUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq: known spectra with hand-derived time-domain results,
// latency, backpressure and mid-frame reset.
module tb_ifft8_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_re, in_im, out_re, out_im;
  int unsigned  n_chk = 0, n_pass = 0, n_fail = 0;
  int unsigned  cnt;

  localparam logic [15:0] Z  = 16'h0000;
  localparam logic [15:0] P  = 16'h0020;   //  32
  localparam logic [15:0] N  = 16'hFFE0;   // -32
  localparam logic [15:0] RN = 16'hFFE9;   // -181/8, floor(-22.625) or floor(-22.125)
`ifdef IFFT_ROUND_EN
  localparam logic [15:0] RP = 16'h0017;   // (181+4)>>>3
`else
  localparam logic [15:0] RP = 16'h0016;   // 181>>>3
`endif

  ifft8_seq #(.DW(16), .FRAC(8), .TW_C(181)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk8(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7);
    return {v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [127:0] xr, input logic [127:0] xi);
    int unsigned w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_re = xr; in_im = xi;
    tick();
    in_valid = 1'b0; in_re = '0; in_im = '0;
  endtask

  // Counts edges after the accepting one until out_valid shows.
  task automatic wait_out(output int unsigned n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
  endtask

  task automatic run_frame(input string tag, input logic [127:0] xr, input logic [127:0] xi,
                           input logic [127:0] er, input logic [127:0] ei);
    send(tag, xr, xi);
    wait_out(cnt);
    chk({tag, " latency"}, 128'(cnt), 128'(6));
    chk({tag, " re"}, out_re, er);
    chk({tag, " im"}, out_im, ei);
    tick();
    chk({tag, " valid_drop"}, 128'(out_valid), 128'(0));
    chk({tag, " ready_back"}, 128'(in_ready), 128'(1));
    chk({tag, " re_held"}, out_re, er);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    tick(); tick();
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst out_re", out_re, '0);
    chk("rst out_im", out_im, '0);
    chk("rst in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", 128'(in_ready), 128'(1));

    run_frame("impulse", pk8(16'h0100, Z, Z, Z, Z, Z, Z, Z), '0,
              pk8(P, P, P, P, P, P, P, P), '0);

    run_frame("dc", pk8(16'h0100, 16'h0100, 16'h0100, 16'h0100,
                        16'h0100, 16'h0100, 16'h0100, 16'h0100), '0,
              pk8(16'h0100, Z, Z, Z, Z, Z, Z, Z), '0);

    run_frame("bin1", pk8(Z, 16'h0100, Z, Z, Z, Z, Z, Z), '0,
              pk8(P, RP, Z, RN, N, RN, Z, RP),
              pk8(Z, RP, P, RP, Z, RN, N, RN));

    run_frame("bin2j", '0, pk8(Z, Z, 16'h0100, Z, Z, Z, Z, Z),
              pk8(Z, N, Z, P, Z, N, Z, P),
              pk8(P, Z, N, Z, P, Z, N, Z));

    // Backpressure: hold out_ready low; a second frame waits on in_valid meanwhile.
    out_ready = 1'b0;
    send("bp", pk8(16'h0100, Z, Z, Z, Z, Z, Z, Z), '0);
    wait_out(cnt);
    chk("bp latency", 128'(cnt), 128'(6));
    in_valid = 1'b1;
    in_re = pk8(Z, 16'h0100, Z, Z, Z, Z, Z, Z);
    in_im = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp valid_hold", 128'(out_valid), 128'(1));
      chk("bp re_hold", out_re, pk8(P, P, P, P, P, P, P, P));
      chk("bp im_hold", out_im, '0);
      chk("bp in_ready_low", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp valid_drop", 128'(out_valid), 128'(0));
    chk("bp in_ready_back", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0; in_re = '0;
    wait_out(cnt);
    chk("bp2 latency", 128'(cnt), 128'(6));
    chk("bp2 re", out_re, pk8(P, RP, Z, RN, N, RN, Z, RP));
    chk("bp2 im", out_im, pk8(Z, RP, P, RP, Z, RN, N, RN));
    tick();
    chk("bp2 valid_drop", 128'(out_valid), 128'(0));

    // Reset while the frame sits in M1 (accept -> S12 -> M0 -> M1).
    send("mid", pk8(16'h0100, 16'h0100, 16'h0100, 16'h0100,
                    16'h0100, 16'h0100, 16'h0100, 16'h0100), '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst out_re", out_re, '0);
    chk("mid_rst out_im", out_im, '0);
    chk("mid_rst in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst in_ready_back", 128'(in_ready), 128'(1));

    run_frame("bin3", pk8(Z, Z, Z, 16'h0100, Z, Z, Z, Z), '0,
              pk8(P, RN, Z, RP, N, RP, Z, RN),
              pk8(Z, RP, N, RP, Z, RN, P, RN));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
